// File: rtl/rx_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// rx_fifo_ctrl
//   Sequencer between the UART receiver and the host logic.
//   - Completes the receiver's four-phase req/ack handshake.
//   - Captures each received byte into a show-ahead FIFO.
//   - Presents the FIFO head on a valid/ready stream.
//   - Reports overrun (byte dropped on a full FIFO), handshake timeout,
//     FIFO fill level and a count of accepted bytes.
//
// Parameters
//   DEPTH        FIFO entries; power of 2, at least 2
//   ACK_TIMEOUT  max cycles rx_ack may wait for rx_req to fall (12-bit counter)
//
// Ports
//   clk       in   system clock, all logic on posedge
//   clr       in   synchronous reset, active-high, overrides every other input
//   en        in   1 = accept bytes; 0 = leave rx_req unanswered
//   rx_req    in   byte-ready request from the receiver
//   rx_data   in   received byte, stable while rx_req=1
//   rx_ack    out  acknowledge to the receiver (registered)
//   m_data    out  FIFO head byte (don't-care while m_valid=0)
//   m_valid   out  FIFO not empty
//   m_ready   in   consumer takes the head byte when m_valid && m_ready
//   level     out  FIFO occupancy, 0..DEPTH
//   overrun   out  sticky: at least one byte was dropped
//   hs_err    out  sticky: handshake timeout occurred
//   err_clr   in   clears overrun/hs_err; a simultaneous set wins
//   byte_cnt  out  bytes accepted into the FIFO, wraps 0xFFFF -> 0
// -----------------------------------------------------------------------------
module rx_fifo_ctrl #(
   parameter int DEPTH       = 16,
   parameter int ACK_TIMEOUT = 4095
) (
   input  logic                      clk,
   input  logic                      clr,
   input  logic                      en,
   input  logic                      rx_req,
   input  logic [7:0]                rx_data,
   output logic                      rx_ack,
   output logic [7:0]                m_data,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic [$clog2(DEPTH):0]    level,
   output logic                      overrun,
   output logic                      hs_err,
   input  logic                      err_clr,
   output logic [15:0]               byte_cnt
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
   localparam logic [LW-1:0] LVL_ONE  = LW'(1);
   localparam logic [LW-1:0] LVL_ZERO = LW'(0);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [PW-1:0] PTR_ZERO = PW'(0);
   localparam logic [11:0]   TMO_MAX  = 12'(ACK_TIMEOUT);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACK  = 2'd1,
      ST_ERR  = 2'd2
   } state_t;

   // Handshake state
   state_t            state_r;
   logic              rx_ack_r;
   logic [11:0]       tmo_r;
   logic              hs_err_r;

   // FIFO storage and bookkeeping
   logic [7:0]        mem_r [DEPTH];
   logic [PW-1:0]     wr_ptr_r;
   logic [PW-1:0]     rd_ptr_r;
   logic [LW-1:0]     level_r;
   logic              m_valid_r;
   logic              overrun_r;
   logic [15:0]       byte_cnt_r;

   // Per-cycle decisions
   logic              capture_s;
   logic              pop_s;
   logic              push_s;
   logic              drop_s;
   logic              hs_set_s;
   logic [LW-1:0]     level_nxt_s;

   // Capture/push/pop decisions and next FIFO level
   always_comb begin
      capture_s   = 1'b0;
      pop_s       = 1'b0;
      push_s      = 1'b0;
      drop_s      = 1'b0;
      hs_set_s    = 1'b0;
      level_nxt_s = level_r;

      // One capture per handshake: only the IDLE cycle that answers rx_req.
      if (!clr && (state_r == ST_IDLE) && en && rx_req) begin
         capture_s = 1'b1;
      end else begin
         capture_s = 1'b0;
      end

      // Pop with an empty FIFO is ignored.
      pop_s = m_valid_r && m_ready;

      // A full FIFO can still take the byte when the head leaves this cycle.
      if (capture_s && ((level_r < LVL_FULL) || pop_s)) begin
         push_s = 1'b1;
      end else begin
         push_s = 1'b0;
      end

      // The ack proceeds even when the byte is dropped, so the receiver never stalls.
      drop_s = capture_s && !push_s;

      if ((state_r == ST_ACK) && rx_req && (tmo_r == TMO_MAX)) begin
         hs_set_s = 1'b1;
      end else begin
         hs_set_s = 1'b0;
      end

      if (push_s && !pop_s) begin
         level_nxt_s = level_r + LVL_ONE;
      end else if (!push_s && pop_s) begin
         level_nxt_s = level_r - LVL_ONE;
      end else begin
         level_nxt_s = level_r;
      end
   end

   // Handshake FSM with registered rx_ack, timeout counter and sticky hs_err
   always_ff @(posedge clk) begin
      if (clr) begin
         state_r  <= ST_IDLE;
         rx_ack_r <= 1'b0;
         tmo_r    <= 12'd0;
         hs_err_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (capture_s) begin
                  rx_ack_r <= 1'b1;
                  tmo_r    <= 12'd0;
                  state_r  <= ST_ACK;
               end else begin
                  rx_ack_r <= 1'b0;
               end
            end
            ST_ACK: begin
               // en is not looked at here: an open handshake always completes.
               if (!rx_req) begin
                  rx_ack_r <= 1'b0;
                  state_r  <= ST_IDLE;
               end else if (tmo_r == TMO_MAX) begin
                  rx_ack_r <= 1'b0;
                  state_r  <= ST_ERR;
               end else begin
                  tmo_r <= tmo_r + 12'd1;
               end
            end
            ST_ERR: begin
               // Wait for the receiver to release rx_req; nothing is captured here.
               rx_ack_r <= 1'b0;
               if (!rx_req) begin
                  state_r <= ST_IDLE;
               end else begin
                  state_r <= ST_ERR;
               end
            end
            default: begin
               rx_ack_r <= 1'b0;
               state_r  <= ST_IDLE;
            end
         endcase

         // Setting wins over a simultaneous clear.
         if (hs_set_s) begin
            hs_err_r <= 1'b1;
         end else if (err_clr) begin
            hs_err_r <= 1'b0;
         end else begin
            hs_err_r <= hs_err_r;
         end
      end
   end

   // FIFO pointers, level, valid flag, overrun flag and accepted-byte counter
   always_ff @(posedge clk) begin
      if (clr) begin
         wr_ptr_r   <= PTR_ZERO;
         rd_ptr_r   <= PTR_ZERO;
         level_r    <= LVL_ZERO;
         m_valid_r  <= 1'b0;
         overrun_r  <= 1'b0;
         byte_cnt_r <= 16'd0;
      end else begin
         // Pointers wrap modulo DEPTH through natural PW-bit overflow.
         if (push_s) begin
            wr_ptr_r   <= wr_ptr_r + PTR_ONE;
            byte_cnt_r <= byte_cnt_r + 16'd1;
         end else begin
            wr_ptr_r   <= wr_ptr_r;
            byte_cnt_r <= byte_cnt_r;
         end

         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end

         level_r   <= level_nxt_s;
         m_valid_r <= (level_nxt_s != LVL_ZERO);

         // Setting wins over a simultaneous clear.
         if (drop_s) begin
            overrun_r <= 1'b1;
         end else if (err_clr) begin
            overrun_r <= 1'b0;
         end else begin
            overrun_r <= overrun_r;
         end
      end
   end

   // FIFO storage; contents need no reset because the pointers define validity
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= rx_data;
      end
   end

   assign rx_ack   = rx_ack_r;
   assign m_data   = mem_r[rd_ptr_r];
   assign m_valid  = m_valid_r;
   assign level    = level_r;
   assign overrun  = overrun_r;
   assign hs_err   = hs_err_r;
   assign byte_cnt = byte_cnt_r;

endmodule

// File: tb/tb_rx_fifo_ctrl.sv
module tb_rx_fifo_ctrl;

   localparam int DEPTH       = 16;
   localparam int ACK_TIMEOUT = 4095;

   logic        clk;
   logic        clr;
   logic        en;
   logic        rx_req;
   logic [7:0]  rx_data;
   logic        rx_ack;
   logic [7:0]  m_data;
   logic        m_valid;
   logic        m_ready;
   logic [4:0]  level;
   logic        overrun;
   logic        hs_err;
   logic        err_clr;
   logic [15:0] byte_cnt;

   int n_cmp;
   int n_bad;

   rx_fifo_ctrl #(.DEPTH(DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
      .clk      (clk),
      .clr      (clr),
      .en       (en),
      .rx_req   (rx_req),
      .rx_data  (rx_data),
      .rx_ack   (rx_ack),
      .m_data   (m_data),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .level    (level),
      .overrun  (overrun),
      .hs_err   (hs_err),
      .err_clr  (err_clr),
      .byte_cnt (byte_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        clr;
      logic        en;
      logic        req;
      logic [7:0]  data;
      logic        mr;
      logic        ec;
      logic        e_ack;
      logic        e_mv;
      logic [7:0]  e_data;
      logic [4:0]  e_lvl;
      logic        e_ov;
      logic        e_hs;
      logic [15:0] e_bc;
   } vec_t;

   vec_t vecs [13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock edge; outputs are then sampled 2 time units after it.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_clr();
      clr = 1'b1; rx_req = 1'b0; m_ready = 1'b0; err_clr = 1'b0; en = 1'b1;
      step();
      clr = 1'b0;
   endtask

   // Full four-phase handshake: req up (capture), then req down.
   task automatic send_byte(input logic [7:0] d, input logic mr);
      rx_req = 1'b1; rx_data = d; m_ready = mr;
      step();
      chk("send_ack_rise", 32'(rx_ack), 32'd1);
      m_ready = 1'b0; rx_req = 1'b0;
      step();
      chk("send_ack_fall", 32'(rx_ack), 32'd0);
   endtask

   task automatic drain_check(input int n, input int first);
      for (int k = 0; k < n; k++) begin
         m_ready = 1'b1;
         chk($sformatf("drain_valid%0d", k), 32'(m_valid), 32'd1);
         chk($sformatf("drain_data%0d", k), 32'(m_data), 32'(first + k));
         step();
      end
      m_ready = 1'b0;
      chk("drain_empty", 32'(m_valid), 32'd0);
      chk("drain_level", 32'(level), 32'd0);
   endtask

   initial begin
      int ack_fall_at;
      n_cmp = 0; n_bad = 0;
      clr = 1'b0; en = 1'b0; rx_req = 1'b0; rx_data = 8'h00;
      m_ready = 1'b0; err_clr = 1'b0;

      //          clr  en   req  data   mr   ec   ack  mv   data   lvl   ov   hs   bc
      vecs[0]  = '{1'b1,1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0,8'h00,5'd0,1'b0,1'b0,16'd0};
      vecs[1]  = '{1'b0,1'b1,1'b1,8'hA5,1'b0,1'b0,1'b1,1'b1,8'hA5,5'd1,1'b0,1'b0,16'd1};
      vecs[2]  = '{1'b0,1'b1,1'b1,8'hA5,1'b0,1'b0,1'b1,1'b1,8'hA5,5'd1,1'b0,1'b0,16'd1};
      vecs[3]  = '{1'b0,1'b1,1'b1,8'hA5,1'b0,1'b0,1'b1,1'b1,8'hA5,5'd1,1'b0,1'b0,16'd1};
      vecs[4]  = '{1'b0,1'b1,1'b1,8'hA5,1'b0,1'b0,1'b1,1'b1,8'hA5,5'd1,1'b0,1'b0,16'd1};
      vecs[5]  = '{1'b0,1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,1'b1,8'hA5,5'd1,1'b0,1'b0,16'd1};
      vecs[6]  = '{1'b0,1'b1,1'b0,8'h00,1'b1,1'b0,1'b0,1'b0,8'h00,5'd0,1'b0,1'b0,16'd1};
      vecs[7]  = '{1'b0,1'b0,1'b1,8'h5A,1'b0,1'b0,1'b0,1'b0,8'h00,5'd0,1'b0,1'b0,16'd1};
      vecs[8]  = '{1'b0,1'b0,1'b1,8'h5A,1'b0,1'b0,1'b0,1'b0,8'h00,5'd0,1'b0,1'b0,16'd1};
      vecs[9]  = '{1'b0,1'b1,1'b1,8'h5A,1'b0,1'b0,1'b1,1'b1,8'h5A,5'd1,1'b0,1'b0,16'd2};
      vecs[10] = '{1'b0,1'b0,1'b1,8'h5A,1'b0,1'b0,1'b1,1'b1,8'h5A,5'd1,1'b0,1'b0,16'd2};
      vecs[11] = '{1'b0,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0,1'b1,8'h5A,5'd1,1'b0,1'b0,16'd2};
      vecs[12] = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b0,1'b0,1'b0,8'h00,5'd0,1'b0,1'b0,16'd2};

      step();

      // Table: reset, single-byte handshake, pop, en gating, en falling mid-ACK
      for (int i = 0; i < 13; i++) begin
         clr = vecs[i].clr; en = vecs[i].en; rx_req = vecs[i].req;
         rx_data = vecs[i].data; m_ready = vecs[i].mr; err_clr = vecs[i].ec;
         step();
         chk($sformatf("vec%0d_ack", i), 32'(rx_ack), 32'(vecs[i].e_ack));
         chk($sformatf("vec%0d_valid", i), 32'(m_valid), 32'(vecs[i].e_mv));
         if (vecs[i].e_mv) begin
            chk($sformatf("vec%0d_data", i), 32'(m_data), 32'(vecs[i].e_data));
         end
         chk($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].e_lvl));
         chk($sformatf("vec%0d_ovr", i), 32'(overrun), 32'(vecs[i].e_ov));
         chk($sformatf("vec%0d_hserr", i), 32'(hs_err), 32'(vecs[i].e_hs));
         chk($sformatf("vec%0d_cnt", i), 32'(byte_cnt), 32'(vecs[i].e_bc));
      end

      // 17 bytes into a 16-deep FIFO with no consumer: last byte dropped
      do_clr();
      for (int b = 0; b < 17; b++) send_byte(8'(b), 1'b0);
      chk("full_level", 32'(level), 32'd16);
      chk("full_ovr", 32'(overrun), 32'd1);
      chk("full_cnt", 32'(byte_cnt), 32'd16);
      drain_check(16, 0);

      // Full FIFO with a pop in the capture cycle: byte accepted, no overrun
      do_clr();
      for (int b = 0; b < 16; b++) send_byte(8'(b), 1'b0);
      send_byte(8'h10, 1'b1);
      chk("pushpop_level", 32'(level), 32'd16);
      chk("pushpop_ovr", 32'(overrun), 32'd0);
      chk("pushpop_cnt", 32'(byte_cnt), 32'd17);
      drain_check(16, 1);

      // Handshake timeout, then a normal capture afterwards
      do_clr();
      rx_req = 1'b1; rx_data = 8'h77;
      step();
      chk("tmo_ack_rise", 32'(rx_ack), 32'd1);
      ack_fall_at = -1;
      for (int c = 1; c <= ACK_TIMEOUT + 5; c++) begin
         step();
         if (ack_fall_at < 0 && rx_ack == 1'b0) ack_fall_at = c;
      end
      chk("tmo_fall_cycle", 32'(ack_fall_at), 32'(ACK_TIMEOUT + 1));
      chk("tmo_ack_low", 32'(rx_ack), 32'd0);
      chk("tmo_hserr", 32'(hs_err), 32'd1);
      chk("tmo_level", 32'(level), 32'd1);
      chk("tmo_cnt", 32'(byte_cnt), 32'd1);
      rx_req = 1'b0;
      step();
      send_byte(8'h3C, 1'b0);
      chk("tmo_after_level", 32'(level), 32'd2);
      chk("tmo_after_cnt", 32'(byte_cnt), 32'd2);
      chk("tmo_hserr_sticky", 32'(hs_err), 32'd1);
      chk("tmo_head", 32'(m_data), 32'h77);
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
      chk("tmo_second", 32'(m_data), 32'h3C);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      chk("tmo_hserr_clr", 32'(hs_err), 32'd0);

      // en=0 for 20 cycles leaves rx_req unanswered; raising en captures next edge
      do_clr();
      en = 1'b0; rx_req = 1'b1; rx_data = 8'h99;
      for (int c = 0; c < 20; c++) begin
         step();
         chk($sformatf("en0_ack%0d", c), 32'(rx_ack), 32'd0);
         chk($sformatf("en0_level%0d", c), 32'(level), 32'd0);
      end
      en = 1'b1;
      step();
      chk("en1_ack", 32'(rx_ack), 32'd1);
      chk("en1_level", 32'(level), 32'd1);
      chk("en1_data", 32'(m_data), 32'h99);
      rx_req = 1'b0;
      step();

      // clr asserted mid-ACK with 3 bytes queued
      do_clr();
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      rx_req = 1'b1; rx_data = 8'h33;
      step();
      chk("clr_pre_level", 32'(level), 32'd3);
      chk("clr_pre_ack", 32'(rx_ack), 32'd1);
      clr = 1'b1;
      step();
      chk("clr_ack", 32'(rx_ack), 32'd0);
      chk("clr_valid", 32'(m_valid), 32'd0);
      chk("clr_level", 32'(level), 32'd0);
      chk("clr_cnt", 32'(byte_cnt), 32'd0);
      chk("clr_ovr", 32'(overrun), 32'd0);
      chk("clr_hserr", 32'(hs_err), 32'd0);
      clr = 1'b0; rx_req = 1'b0;
      step();

      // New overrun with err_clr in the same cycle: the set wins
      for (int b = 0; b < 16; b++) send_byte(8'(b), 1'b0);
      rx_req = 1'b1; rx_data = 8'hEE; err_clr = 1'b1;
      step();
      chk("ovr_set_wins", 32'(overrun), 32'd1);
      err_clr = 1'b0; rx_req = 1'b0;
      step();
      chk("ovr_sticky", 32'(overrun), 32'd1);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      chk("ovr_clr", 32'(overrun), 32'd0);
      chk("ovr_level", 32'(level), 32'd16);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
